spi_master_ctrl: RTL
====================

Name: spi_master_ctrl

Overview:
- Master end of the on-chip SPI link feeding the SPI slave / dual-port RAM wrapper.
- Accepts 10-bit command words from a host and serialises each one MSB-first on MOSI under SS_n, one bit per clk.
- For read-data commands (bits [9:8]=2'b11), holds SS_n low, captures the 8-bit RAM byte returned on MISO and presents it to the host with a one-cycle valid pulse.

Parameters:
- FRAME_W, 10, command word width; bits [FRAME_W-1:FRAME_W-2] are the command code.
- RD_W, 8, width of the read byte returned on MISO.
- TURNAROUND, 2, clk cycles between the last MOSI bit of a read-data frame and the first MISO sample (range 1..15).
- IDLE_GAP, 1, minimum clk cycles SS_n stays high between frames (range 1..15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host presents a command word.
- cmd_data  in  FRAME_W  command word: code in [9:8], address/data in [7:0].
- cmd_ready  out  1  high only in IDLE; the word is accepted on a clk edge where cmd_valid and cmd_ready are both high.
- rd_data  out  RD_W  byte captured from MISO; holds its value until the next capture.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- busy  out  1  high from accept until IDLE is re-entered.
- SS_n  out  1  active-low slave select.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (async, immediate): SS_n=1, MOSI=0, cmd_ready=1, busy=0, rd_valid=0, rd_data=0, all counters=0, state=IDLE.
- Reset mid-frame: the frame is aborted, SS_n rises asynchronously and no rd_valid is issued.
- Registered outputs: SS_n, MOSI, rd_valid and rd_data are flops. cmd_ready and busy are decoded from state.
- IDLE: SS_n=1, MOSI=0. On accept, latch cmd_data into the shift register and go to START.
- START (1 cycle): SS_n=0, MOSI=word[9]. This is the slave's command-check slot.
- SHIFT (FRAME_W cycles): MOSI=word[9], word[8], ..., word[0], one bit per cycle. Bit counter counts FRAME_W-1 down to 0.
- After the last SHIFT cycle: if code==2'b11 go to TURN, else go to GAP.
- TURN (TURNAROUND cycles): SS_n=0, MOSI=0.
- CAPTURE (RD_W cycles): SS_n=0, MOSI=0. MISO is sampled each posedge and shifted in MSB-first.
  - On the last sample, load rd_data and assert rd_valid in the next cycle.
  - In that same next cycle, SS_n=1 and the state enters GAP.
- GAP (IDLE_GAP cycles): SS_n=1, MOSI=0. Then go to IDLE; cmd_ready rises.
- Latency, accept edge at T:
  - SS_n falls at T+1.
  - Non-read frame: SS_n rises at T+2+FRAME_W; cmd_ready rises at T+2+FRAME_W+IDLE_GAP.
  - Read-data frame: rd_valid at T+2+FRAME_W+TURNAROUND+RD_W.
- Back-to-back commands: cmd_valid while busy is not accepted (cmd_ready=0), so the host must hold it. A word held continuously is accepted on the first IDLE cycle.
- Code handling:
  - Codes 00, 01 and 10 produce identical waveforms.
  - Only 11 enters TURN/CAPTURE; the master does not track the slave's read-address/read-data pairing.
- rd_valid never coincides with cmd_ready=1 on the same cycle.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum for IDLE, START, SHIFT, TURN, CAPTURE, GAP;
  - localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FRAME_W and RD_W defaults.
- One sub-module, spi_shift_reg: a parameterised width register with a parallel-load, shift-out (MSB) and shift-in (LSB) enable.
  - One instance handles the transmit side, one the receive side.

Test Plan:
- Reset then idle: hold rst high for 3 cycles -> SS_n=1, MOSI=0, cmd_ready=1, busy=0, rd_valid=0, rd_data=8'h00.
- Write address: cmd_data=10'b00_1010_0101 accepted at T -> SS_n=0 for T+1..T+11; MOSI=0 at T+1, then 0,0,1,0,1,0,0,1,0,1 over T+2..T+11; SS_n=1 at T+12; cmd_ready=1 at T+13; no rd_valid.
- Read data: cmd_data=10'b11_0000_0000, slave model drives MISO=8'hC3 MSB-first starting T+14 (TURNAROUND=2) -> SS_n stays low through T+21; rd_valid pulses at T+22 with rd_data=8'hC3; SS_n=1 at T+22.
- Back-to-back: cmd_valid held high with 10'h155 then 10'h2AA -> second accept exactly IDLE_GAP+1 cycles after SS_n rises; cmd_ready low throughout the first frame.
- Reset mid-read: assert rst during CAPTURE bit 4 -> SS_n=1 in the same cycle (async); rd_valid never pulses; rd_data=0; the next command runs a normal full frame.
- Full system: master + spi_slave + RAM; write addr 8'h10, write data 8'h5A, read addr 8'h10, read data -> rd_data=8'h5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
// Command codes occupy the top two bits of every frame.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_TURN,
    ST_CAPTURE,
    ST_GAP
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int DEF_FRAME_W = 10;
  localparam int DEF_RD_W    = 8;

  // Only read-data frames hold the link for a returned byte.
  function automatic logic is_read_cmd(input logic [1:0] code);
    return code == CMD_RD_DATA;
  endfunction

  // One down-counter serves every phase; size it for the longest phase or 15.
  function automatic int cnt_width(input int frame_w, input int rd_w);
    int m;
    m = (frame_w > rd_w) ? frame_w : rd_w;
    if (m < 16) m = 16;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parameterised shift register: parallel load, shift towards the MSB,
// serial data entering at the LSB. Load has priority over shift.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         serial_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[W-2:0], serial_in};
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: serialises host command words MSB-first under SS_n and, for
// read-data commands, captures the byte returned on MISO.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int RD_W       = DEF_RD_W,
  parameter int TURNAROUND = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [FRAME_W-1:0] cmd_data,
  output logic               cmd_ready,
  output logic [RD_W-1:0]    rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO,
  output state_t             state
);

  // Handshake: a command word transfers on a rising clk edge where
  // cmd_valid and cmd_ready are both high; cmd_ready is high only in IDLE,
  // so a host must hold cmd_valid and cmd_data stable until that edge.

  localparam int CNT_W = cnt_width(FRAME_W, RD_W);

  logic [CNT_W-1:0]   cnt;
  logic               is_read;
  logic               accept;
  logic               tx_shift;
  logic               rx_shift;
  logic [FRAME_W-1:0] tx_q;
  logic [RD_W-1:0]    rx_q;
  logic               tx_msb;
  logic               unused_bits;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign tx_msb    = tx_q[FRAME_W-1];

  // The transmit word advances once leaving START and once per SHIFT bit
  // except the last, so tx_msb always holds the next bit to drive.
  assign tx_shift = (state == ST_START) || ((state == ST_SHIFT) && (cnt != '0));
  assign rx_shift = (state == ST_CAPTURE);

  // Lower transmit bits are only observed once they reach the MSB, and the
  // top receive bit is consumed through the final rd_data load instead.
  assign unused_bits = ^{tx_q[FRAME_W-2:0], rx_q[RD_W-1]};

  spi_shift_reg #(.W(FRAME_W)) u_tx_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (cmd_data),
    .shift_en  (tx_shift),
    .serial_in (1'b0),
    .q         (tx_q)
  );

  spi_shift_reg #(.W(RD_W)) u_rx_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (rx_shift),
    .serial_in (MISO),
    .q         (rx_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      is_read  <= 1'b0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (accept) begin
            state   <= ST_START;
            is_read <= is_read_cmd(cmd_data[FRAME_W-1 -: 2]);
            SS_n    <= 1'b0;
            MOSI    <= cmd_data[FRAME_W-1];
          end
        end
        ST_START: begin
          state <= ST_SHIFT;
          cnt   <= CNT_W'(FRAME_W - 1);
          MOSI  <= tx_msb;
        end
        ST_SHIFT: begin
          if (cnt != '0) begin
            cnt  <= cnt - 1'b1;
            MOSI <= tx_msb;
          end else begin
            MOSI <= 1'b0;
            if (is_read) begin
              state <= ST_TURN;
              cnt   <= CNT_W'(TURNAROUND - 1);
            end else begin
              state <= ST_GAP;
              SS_n  <= 1'b1;
              cnt   <= CNT_W'(IDLE_GAP - 1);
            end
          end
        end
        ST_TURN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= ST_CAPTURE;
            cnt   <= CNT_W'(RD_W - 1);
          end
        end
        ST_CAPTURE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Last MISO bit goes straight into rd_data alongside the seven already shifted in.
            rd_data  <= {rx_q[RD_W-2:0], MISO};
            rd_valid <= 1'b1;
            SS_n     <= 1'b1;
            state    <= ST_GAP;
            cnt      <= CNT_W'(IDLE_GAP - 1);
          end
        end
        ST_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          SS_n  <= 1'b1;
          MOSI  <= 1'b0;
        end
      endcase
    end
  end

endmodule
